// File: rtl/de4_sopc_version_rom_arbiter.sv
// Two-master round-robin front end for the SOPC version ROM (s0 = CPU data, s1 = JTAG/debug).
// Latency: command accepted combinationally, read response exactly one cycle after accept.
// Backpressure: the losing requester, or any port during reset, sees waitrequest=1 and must hold its command.
//
// Ports:
//   clk, reset            - sole clock, synchronous active-high reset
//   s0_*, s1_*            - Avalon-MM slave ports (s1 additionally carries debugaccess)
//   rom_*                 - single-port on-chip RAM (registered address, unregistered data out)
//   wr_reject             - one-cycle pulse for an accepted but dropped write
module de4_sopc_version_rom_arbiter #(
    parameter int                NUM_WORDS = 5,
    parameter int                ADDR_W    = 3,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] OOR_DATA  = '0
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     s0_address,
    input  logic                  s0_read,
    input  logic                  s0_write,
    input  logic [DATA_W-1:0]     s0_writedata,
    input  logic [DATA_W/8-1:0]   s0_byteenable,
    output logic                  s0_waitrequest,
    output logic [DATA_W-1:0]     s0_readdata,
    output logic                  s0_readdatavalid,

    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W-1:0]     s1_writedata,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic                  s1_debugaccess,
    output logic                  s1_waitrequest,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,

    output logic [ADDR_W-1:0]     rom_address,
    output logic                  rom_chipselect,
    output logic                  rom_write,
    output logic                  rom_debugaccess,
    output logic [DATA_W-1:0]     rom_writedata,
    output logic [DATA_W/8-1:0]   rom_byteenable,
    output logic                  rom_clken,
    input  logic [DATA_W-1:0]     rom_readdata,

    output logic                  wr_reject
);

    localparam logic [ADDR_W:0] LIMIT = NUM_WORDS[ADDR_W:0];

    // last_grant_q: 0 = s0 was last accepted, 1 = s1 was last accepted
    logic last_grant_q, last_grant_d;
    logic rsp_vld_q, rsp_vld_d;
    logic rsp_owner_q, rsp_owner_d;
    logic rsp_oor_q, rsp_oor_d;
    logic wr_reject_q, wr_reject_d;
    logic [DATA_W-1:0] s0_rdata_q, s1_rdata_q;

    logic s0_req, s1_req, gnt0, gnt1, acc;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_read, sel_write, sel_oor, wr_permit;
    logic [DATA_W-1:0]   sel_wdata, rsp_data;
    logic [DATA_W/8-1:0] sel_be;
    logic                s0_rdv, s1_rdv;

    assign s0_req = s0_read | s0_write;
    assign s1_req = s1_read | s1_write;

    // On a tie the port that did not win last time is served.
    assign gnt0 = !reset && s0_req && (!s1_req ||  last_grant_q);
    assign gnt1 = !reset && s1_req && (!s0_req || !last_grant_q);
    assign acc  = gnt0 | gnt1;

    assign s0_waitrequest = !gnt0;
    assign s1_waitrequest = !gnt1;

    always_comb begin
        sel_addr  = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        sel_wdata = '0;
        sel_be    = '0;
        if (gnt0) begin
            sel_addr  = s0_address;
            sel_read  = s0_read;
            sel_write = s0_write;
            sel_wdata = s0_writedata;
            sel_be    = s0_byteenable;
        end else if (gnt1) begin
            sel_addr  = s1_address;
            sel_read  = s1_read;
            sel_write = s1_write;
            sel_wdata = s1_writedata;
            sel_be    = s1_byteenable;
        end
    end

    assign sel_oor = ({1'b0, sel_addr} >= LIMIT);

    // Read wins over a simultaneous write; only privileged in-range s1 writes reach the ROM.
    assign wr_permit = gnt1 && sel_write && !sel_read && s1_debugaccess && !sel_oor;

    assign rom_address     = sel_addr;
    assign rom_chipselect  = acc && !sel_oor && (sel_read || wr_permit);
    assign rom_write       = wr_permit;
    assign rom_debugaccess = wr_permit;
    assign rom_writedata   = sel_wdata;
    assign rom_byteenable  = sel_be;
    assign rom_clken       = 1'b1;

    always_comb begin
        last_grant_d = acc ? gnt1 : last_grant_q;
        rsp_vld_d    = acc && sel_read;
        rsp_owner_d  = gnt1;
        rsp_oor_d    = sel_oor;
        wr_reject_d  = acc && sel_write && !wr_permit;
    end

    // Response outputs are masked by reset so an in-flight read is dropped when reset arrives.
    assign rsp_data = rsp_oor_q ? OOR_DATA : rom_readdata;
    assign s0_rdv   = rsp_vld_q && !rsp_owner_q && !reset;
    assign s1_rdv   = rsp_vld_q &&  rsp_owner_q && !reset;

    assign s0_readdatavalid = s0_rdv;
    assign s1_readdatavalid = s1_rdv;
    assign s0_readdata      = s0_rdv ? rsp_data : s0_rdata_q;
    assign s1_readdata      = s1_rdv ? rsp_data : s1_rdata_q;
    assign wr_reject        = wr_reject_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rsp_vld_q    <= 1'b0;
            rsp_owner_q  <= 1'b0;
            rsp_oor_q    <= 1'b0;
            wr_reject_q  <= 1'b0;
            s0_rdata_q   <= '0;
            s1_rdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_owner_q  <= rsp_owner_d;
            rsp_oor_q    <= rsp_oor_d;
            wr_reject_q  <= wr_reject_d;
            if (s0_rdv) s0_rdata_q <= rsp_data;
            if (s1_rdv) s1_rdata_q <= rsp_data;
        end
    end

endmodule

// File: tb/tb_de4_sopc_version_rom_arbiter.sv
// Directed bench for the version ROM arbiter with a behavioural 5x32 ROM behind it.
// Inputs change 2ns after the rising edge; outputs are sampled 1ns later.
// Every comparison funnels through check().
module tb_de4_sopc_version_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  s0_address, s1_address;
    logic        s0_read, s0_write, s1_read, s1_write, s1_debugaccess;
    logic [31:0] s0_writedata, s1_writedata;
    logic [3:0]  s0_byteenable, s1_byteenable;
    logic        s0_waitrequest, s1_waitrequest;
    logic [31:0] s0_readdata, s1_readdata;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic [2:0]  rom_address;
    logic        rom_chipselect, rom_write, rom_debugaccess, rom_clken;
    logic [31:0] rom_writedata, rom_readdata;
    logic [3:0]  rom_byteenable;
    logic        wr_reject;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    de4_sopc_version_rom_arbiter dut (
        .clk(clk), .reset(reset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
        .s1_debugaccess(s1_debugaccess),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .rom_address(rom_address), .rom_chipselect(rom_chipselect),
        .rom_write(rom_write), .rom_debugaccess(rom_debugaccess),
        .rom_writedata(rom_writedata), .rom_byteenable(rom_byteenable),
        .rom_clken(rom_clken), .rom_readdata(rom_readdata),
        .wr_reject(wr_reject)
    );

    // ROM model: registered address, unregistered data out, byte-enabled writes.
    logic [31:0] mem [5];
    logic [2:0]  rom_addr_q = '0;
    initial begin
        mem[0] = 32'h1111_0000;
        mem[1] = 32'hAAAA_0001;
        mem[2] = 32'h2012_0315;
        mem[3] = 32'h3333_0003;
        mem[4] = 32'h4444_0004;
    end
    always @(posedge clk) begin
        if (rom_clken && rom_chipselect) begin
            if (rom_write)
                for (int b = 0; b < 4; b++)
                    if (rom_byteenable[b]) mem[rom_address][b*8 +: 8] <= rom_writedata[b*8 +: 8];
            rom_addr_q <= rom_address;
        end
    end
    assign rom_readdata = (rom_addr_q < 3'd5) ? mem[rom_addr_q] : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0; s1_debugaccess = 0;
        s0_address = 0; s1_address = 0;
        s0_writedata = 0; s1_writedata = 0;
        s0_byteenable = 4'hF; s1_byteenable = 4'hF;
    endtask

    int r0, r1;

    initial begin
        idle();
        reset = 1;
        cyc(); cyc();
        // Requests during reset must be stalled and never reach the ROM.
        s0_read = 1; s1_read = 1;
        #1;
        check("rst_wait0", s0_waitrequest, 1);
        check("rst_wait1", s1_waitrequest, 1);
        check("rst_cs", rom_chipselect, 0);
        check("rst_rdv0", s0_readdatavalid, 0);
        check("rst_rdv1", s1_readdatavalid, 0);
        check("rst_rd0", s0_readdata, 0);
        check("rst_rd1", s1_readdata, 0);
        check("rst_wrrej", wr_reject, 0);
        check("clken", rom_clken, 1);
        cyc();
        reset = 0;

        // Tie after reset: s0 first, s1 next cycle.
        s0_read = 1; s0_address = 0; s1_read = 1; s1_address = 1;
        #1;
        check("tie_wait0", s0_waitrequest, 0);
        check("tie_wait1", s1_waitrequest, 1);
        check("tie_addr0", rom_address, 0);
        check("tie_cs0", rom_chipselect, 1);
        cyc();
        s0_read = 0;
        #1;
        check("tie_wait1b", s1_waitrequest, 0);
        check("tie_addr1", rom_address, 1);
        check("tie_rdv0", s0_readdatavalid, 1);
        check("tie_rd0", s0_readdata, 32'h1111_0000);
        check("tie_rdv1a", s1_readdatavalid, 0);
        cyc();
        idle();
        #1;
        check("tie_rdv1", s1_readdatavalid, 1);
        check("tie_rd1", s1_readdata, 32'hAAAA_0001);
        check("tie_rdv0b", s0_readdatavalid, 0);
        check("tie_hold0", s0_readdata, 32'h1111_0000);
        cyc();

        // Continuous contention: strict alternation, no bubbles.
        r0 = 0; r1 = 0;
        for (int i = 0; i < 8; i++) begin
            s0_read = 1; s0_address = 3; s1_read = 1; s1_address = 4;
            #1;
            check("rr_wait0", s0_waitrequest, (i % 2) != 0);
            check("rr_wait1", s1_waitrequest, (i % 2) == 0);
            check("rr_cs", rom_chipselect, 1);
            if (i > 0) check("rr_rdv0", s0_readdatavalid, ((i - 1) % 2) == 0);
            if (s0_readdatavalid) begin r0++; check("rr_rd0", s0_readdata, 32'h3333_0003); end
            if (s1_readdatavalid) begin r1++; check("rr_rd1", s1_readdata, 32'h4444_0004); end
            cyc();
        end
        idle();
        #1;
        if (s0_readdatavalid) r0++;
        if (s1_readdatavalid) r1++;
        check("rr_cnt0", r0, 4);
        check("rr_cnt1", r1, 4);
        cyc();

        // Single s0 read of word 2.
        s0_read = 1; s0_address = 2;
        #1;
        check("rd_cs", rom_chipselect, 1);
        check("rd_addr", rom_address, 2);
        check("rd_wait0", s0_waitrequest, 0);
        cyc();
        idle();
        #1;
        check("rd_rdv", s0_readdatavalid, 1);
        check("rd_data", s0_readdata, 32'h2012_0315);
        check("rd_rdv1", s1_readdatavalid, 0);
        cyc();

        // Out-of-range read.
        s0_read = 1; s0_address = 6;
        #1;
        check("oor_cs", rom_chipselect, 0);
        check("oor_wait", s0_waitrequest, 0);
        cyc();
        idle();
        #1;
        check("oor_rdv", s0_readdatavalid, 1);
        check("oor_data", s0_readdata, 32'h0);
        cyc();

        // Unprivileged write from s0 is dropped.
        s0_write = 1; s0_address = 1; s0_writedata = 32'hFFFF_FFFF;
        #1;
        check("rej_wait", s0_waitrequest, 0);
        check("rej_wr", rom_write, 0);
        check("rej_cs", rom_chipselect, 0);
        cyc();
        idle();
        #1;
        check("rej_pulse", wr_reject, 1);
        check("rej_rdv", s0_readdatavalid, 0);
        cyc();
        s0_read = 1; s0_address = 1;
        #1;
        check("rej_pulse_end", wr_reject, 0);
        cyc();
        idle();
        #1;
        check("rej_readback", s0_readdata, 32'hAAAA_0001);
        cyc();

        // Privileged write from s1, then read back.
        s1_write = 1; s1_address = 4; s1_writedata = 32'hCAFE_0001; s1_debugaccess = 1;
        #1;
        check("wr_wr", rom_write, 1);
        check("wr_cs", rom_chipselect, 1);
        check("wr_dbg", rom_debugaccess, 1);
        check("wr_data", rom_writedata, 32'hCAFE_0001);
        cyc();
        idle();
        #1;
        check("wr_norej", wr_reject, 0);
        check("wr_nordv", s1_readdatavalid, 0);
        cyc();
        s1_read = 1; s1_address = 4;
        cyc();
        idle();
        #1;
        check("wr_rdv", s1_readdatavalid, 1);
        check("wr_readback", s1_readdata, 32'hCAFE_0001);
        cyc();

        // Read and write together on one port: read performed, write rejected.
        s1_read = 1; s1_write = 1; s1_debugaccess = 1; s1_address = 3; s1_writedata = 32'hDEAD_BEEF;
        #1;
        check("rw_wr", rom_write, 0);
        check("rw_cs", rom_chipselect, 1);
        cyc();
        idle();
        #1;
        check("rw_rdv", s1_readdatavalid, 1);
        check("rw_data", s1_readdata, 32'h3333_0003);
        check("rw_rej", wr_reject, 1);
        cyc();

        // Reset while an s1 response is in flight.
        s1_read = 1; s1_address = 0;
        #1;
        check("fl_wait1", s1_waitrequest, 0);
        cyc();
        idle();
        reset = 1;
        #1;
        check("fl_rdv1", s1_readdatavalid, 0);
        cyc();
        reset = 0;
        #1;
        check("fl_rdv1b", s1_readdatavalid, 0);
        check("fl_hold1", s1_readdata, 32'h0);
        s0_read = 1; s0_address = 2; s1_read = 1; s1_address = 0;
        #1;
        check("fl_tie0", s0_waitrequest, 0);
        check("fl_tie1", s1_waitrequest, 1);
        cyc();
        idle();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
